pixel_fb_writer: RTL and testbench

- Stage directly downstream of the special-effects colour processor.
- Accepts one final 16-bit BGR555 pixel per transfer over a valid/ready handshake and buffers it in a small FIFO.
- Walks raster position (x, y) across a 240x160 frame and issues single-word writes into the frame buffer memory, with a per-write stall ack.
- Emits line_done / frame_done strobes for the display controller and interrupt logic.

---
 rtl/pixel_fb_writer.sv | 159 +++++++++++++++
 tb/tb_pixel_fb_writer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_fb_writer.sv
`default_nettype none
// ============================================================================
// Module   : pixel_fb_writer
// Brief    : Buffers BGR555 pixels and writes them in raster order into the
//            frame buffer. Optional macro: PIXEL_FB_FORCED_BLANK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pixel_fb_writer #(
    parameter int H_PIXELS   = 240,
    parameter int V_LINES    = 160,
    parameter int ADDR_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic [15:0]       pix_color,
    output logic              fb_wr_en,
    output logic [ADDR_W-1:0] fb_wr_addr,
    output logic [15:0]       fb_wr_data,
    input  logic              fb_wr_ack,
`ifdef PIXEL_FB_FORCED_BLANK_EN
    input  logic              forced_blank,
`endif
    output logic              line_done,
    output logic              frame_done,
    output logic [7:0]        pix_x,
    output logic [7:0]        pix_y
);

    localparam int                 c_PTR_W  = $clog2(FIFO_DEPTH);
    localparam int                 c_CNT_W  = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL   = c_CNT_W'(FIFO_DEPTH);
    localparam logic [7:0]         c_X_LAST = 8'(H_PIXELS - 1);
    localparam logic [7:0]         c_Y_LAST = 8'(V_LINES - 1);

    logic [14:0]         r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic [c_CNT_W-1:0]  w_count_nxt;
    logic                r_pix_ready;
    logic [ADDR_W-1:0]   r_addr;
    logic [7:0]          r_x;
    logic [7:0]          r_y;
    logic                r_line_done;
    logic                r_frame_done;

    logic                w_push;
    logic                w_pop;
    logic                w_wr_en;
    logic                w_x_last;
    logic                w_y_last;
    logic [14:0]         w_head;
    logic                w_unused_bit;

    // Bit 15 of the incoming colour carries no information for the frame buffer.
    assign w_unused_bit = pix_color[15];

    assign w_wr_en  = (r_count != '0);
    assign w_push   = pix_valid && r_pix_ready && !frame_start;
    assign w_pop    = w_wr_en && fb_wr_ack && !frame_start;
    assign w_x_last = (r_x == c_X_LAST);
    assign w_y_last = (r_y == c_Y_LAST);
    assign w_head   = r_mem[r_rd_ptr];

    always_comb begin
        w_count_nxt = r_count;
        if (frame_start) begin
            w_count_nxt = '0;
        end else if (w_push && !w_pop) begin
            w_count_nxt = r_count + c_CNT_W'(1);
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - c_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= pix_color[14:0];
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_pix_ready <= 1'b1;
        end else begin
            r_count     <= w_count_nxt;
            r_pix_ready <= (w_count_nxt != c_FULL);
            if (frame_start) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
                end
            end
        end
    end

    // Raster position and linear address advance together on every accepted write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr       <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_line_done  <= 1'b0;
            r_frame_done <= 1'b0;
        end else if (frame_start) begin
            r_addr       <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_line_done  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_line_done  <= w_pop && w_x_last;
            r_frame_done <= w_pop && w_x_last && w_y_last;
            if (w_pop) begin
                r_addr <= (w_x_last && w_y_last) ? '0 : r_addr + ADDR_W'(1);
                if (w_x_last) begin
                    r_x <= '0;
                    r_y <= w_y_last ? 8'd0 : r_y + 8'd1;
                end else begin
                    r_x <= r_x + 8'd1;
                end
            end
        end
    end

    always_comb begin
        fb_wr_data = 16'h0000;
        if (w_wr_en) begin
`ifdef PIXEL_FB_FORCED_BLANK_EN
            fb_wr_data = forced_blank ? 16'h7FFF : {1'b0, w_head};
`else
            fb_wr_data = {1'b0, w_head};
`endif
        end
    end

    assign pix_ready  = r_pix_ready;
    assign fb_wr_en   = w_wr_en;
    assign fb_wr_addr = r_addr;
    assign line_done  = r_line_done;
    assign frame_done = r_frame_done;
    assign pix_x      = r_x;
    assign pix_y      = r_y;

endmodule
`default_nettype wire

// File: tb/tb_pixel_fb_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pixel_fb_writer
// Brief    : Self-checking bench for pixel_fb_writer against a queue-based
//            raster model. Honours PIXEL_FB_FORCED_BLANK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pixel_fb_writer;

    localparam int H     = 240;
    localparam int V     = 160;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_start = 1'b0;
    logic        pix_valid = 1'b0;
    logic [15:0] pix_color = 16'h0;
    logic        fb_wr_ack = 1'b0;
`ifdef PIXEL_FB_FORCED_BLANK_EN
    logic        forced_blank = 1'b0;
`endif
    logic        pix_ready;
    logic        fb_wr_en;
    logic [15:0] fb_wr_addr;
    logic [15:0] fb_wr_data;
    logic        line_done;
    logic        frame_done;
    logic [7:0]  pix_x;
    logic [7:0]  pix_y;

    pixel_fb_writer #(
        .H_PIXELS  (H),
        .V_LINES   (V),
        .ADDR_W    (16),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_start(frame_start),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_color  (pix_color),
        .fb_wr_en   (fb_wr_en),
        .fb_wr_addr (fb_wr_addr),
        .fb_wr_data (fb_wr_data),
        .fb_wr_ack  (fb_wr_ack),
`ifdef PIXEL_FB_FORCED_BLANK_EN
        .forced_blank(forced_blank),
`endif
        .line_done  (line_done),
        .frame_done (frame_done),
        .pix_x      (pix_x),
        .pix_y      (pix_y)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int ld_count = 0;
    int fd_count = 0;

    // Reference model: pending colours plus raster coordinates.
    logic [14:0] mq[$];
    int          mx = 0;
    int          my = 0;
    bit          mld = 1'b0;
    bit          mfd = 1'b0;

    typedef struct {
        bit          fs;
        bit          v;
        logic [15:0] c;
        bit          a;
        bit          en;
        logic [15:0] addr;
        logic [15:0] data;
        logic [7:0]  x;
        bit          rdy;
    } vec_t;

    vec_t tbl[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [51:0] dut_vec();
        return {pix_ready, fb_wr_en, fb_wr_addr, fb_wr_data, pix_x, pix_y, line_done, frame_done};
    endfunction

    function automatic logic [51:0] model_vec();
        logic        en;
        logic        rdy;
        logic [15:0] d;
        logic [15:0] a;
        en  = (mq.size() != 0);
        rdy = (mq.size() != DEPTH);
        d   = 16'h0000;
        if (en) begin
            d = {1'b0, mq[0]};
`ifdef PIXEL_FB_FORCED_BLANK_EN
            if (forced_blank) d = 16'h7FFF;
`endif
        end
        a = 16'(my * H + mx);
        return {rdy, en, a, d, 8'(mx), 8'(my), mld, mfd};
    endfunction

    task automatic model_reset();
        mq.delete();
        mx  = 0;
        my  = 0;
        mld = 1'b0;
        mfd = 1'b0;
    endtask

    task automatic model_edge();
        bit en;
        bit push;
        bit pop;
        en   = (mq.size() != 0);
        push = pix_valid && (mq.size() != DEPTH);
        pop  = en && fb_wr_ack;
        mld  = 1'b0;
        mfd  = 1'b0;
        if (frame_start) begin
            mq.delete();
            mx = 0;
            my = 0;
        end else begin
            if (pop) begin
                void'(mq.pop_front());
                mx++;
                if (mx == H) begin
                    mx  = 0;
                    mld = 1'b1;
                    my++;
                    if (my == V) begin
                        my  = 0;
                        mfd = 1'b1;
                    end
                end
            end
            if (push) mq.push_back(pix_color[14:0]);
        end
    endtask

    task automatic cycle(input bit fs, input bit v, input logic [15:0] c, input bit a);
        frame_start = fs;
        pix_valid   = v;
        pix_color   = c;
        fb_wr_ack   = a;
        @(posedge clk);
        model_edge();
        #1;
        check("cycle", 64'(dut_vec()), 64'(model_vec()));
        if (line_done)  ld_count++;
        if (frame_done) fd_count++;
    endtask

    initial begin
        tbl[0]  = '{1'b0, 1'b1, 16'h801F, 1'b1, 1'b1, 16'd0, 16'h001F, 8'd0, 1'b1};
        tbl[1]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'd1, 16'h0000, 8'd1, 1'b1};
        tbl[2]  = '{1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1, 16'd1, 16'h7FFF, 8'd1, 1'b1};
        tbl[3]  = '{1'b0, 1'b1, 16'h0001, 1'b0, 1'b1, 16'd1, 16'h7FFF, 8'd1, 1'b1};
        tbl[4]  = '{1'b0, 1'b1, 16'h0002, 1'b0, 1'b1, 16'd1, 16'h7FFF, 8'd1, 1'b1};
        tbl[5]  = '{1'b0, 1'b1, 16'h8003, 1'b0, 1'b1, 16'd1, 16'h7FFF, 8'd1, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 16'h0004, 1'b0, 1'b1, 16'd1, 16'h7FFF, 8'd1, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'd2, 16'h0001, 8'd2, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'd3, 16'h0002, 8'd3, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'd4, 16'h0003, 8'd4, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'd5, 16'h0000, 8'd5, 1'b1};

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 64'(dut_vec()), 64'(52'h8000000000000));
        rst_n = 1'b1;
        model_reset();

        for (int i = 0; i < 11; i++) begin
            cycle(tbl[i].fs, tbl[i].v, tbl[i].c, tbl[i].a);
            check($sformatf("table_row%0d", i),
                  64'({fb_wr_en, fb_wr_addr, fb_wr_data, pix_x, pix_ready}),
                  64'({tbl[i].en, tbl[i].addr, tbl[i].data, tbl[i].x, tbl[i].rdy}));
        end

        // One full line streamed with continuous ack.
        cycle(1'b1, 1'b0, 16'h0, 1'b0);
        ld_count = 0;
        for (int i = 0; i < H; i++) cycle(1'b0, 1'b1, 16'($urandom), 1'b1);
        cycle(1'b0, 1'b0, 16'h0, 1'b1);
        check("line_done_count", 64'(ld_count), 64'd1);
        check("line_end_pos", 64'({fb_wr_addr, pix_x, pix_y}), 64'({16'd240, 8'd0, 8'd1}));

        // One full frame; both strobes coincide after the last write.
        cycle(1'b1, 1'b0, 16'h0, 1'b0);
        ld_count = 0;
        fd_count = 0;
        for (int i = 0; i < H * V; i++) cycle(1'b0, 1'b1, 16'($urandom), 1'b1);
        cycle(1'b0, 1'b0, 16'h0, 1'b1);
        check("frame_done_count", 64'(fd_count), 64'd1);
        check("frame_line_count", 64'(ld_count), 64'(V));
        check("frame_end_pos", 64'({fb_wr_addr, pix_x, pix_y}), 64'({16'd0, 8'd0, 8'd0}));

        // frame_start mid-line with a pending write and three buffered pixels.
        cycle(1'b1, 1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 100; i++) cycle(1'b0, 1'b1, 16'($urandom), 1'b1);
        cycle(1'b0, 1'b0, 16'h0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 16'h1000 + 16'(i), 1'b0);
        check("pre_flush", 64'({fb_wr_en, fb_wr_addr, fb_wr_data}), 64'({1'b1, 16'd100, 16'h1000}));
        cycle(1'b1, 1'b1, 16'h5555, 1'b1);
        check("flush_state", 64'({fb_wr_en, fb_wr_addr, pix_x, pix_y, pix_ready}),
              64'({1'b0, 16'd0, 8'd0, 8'd0, 1'b1}));
        cycle(1'b0, 1'b0, 16'h0, 1'b1);
        check("flush_dropped_push", 64'(fb_wr_en), 64'd0);

`ifdef PIXEL_FB_FORCED_BLANK_EN
        forced_blank = 1'b1;
        cycle(1'b0, 1'b1, 16'h1234, 1'b0);
        check("blank_write", 64'({fb_wr_en, fb_wr_addr, fb_wr_data}), 64'({1'b1, 16'd0, 16'h7FFF}));
        cycle(1'b0, 1'b0, 16'h0, 1'b1);
        forced_blank = 1'b0;
        cycle(1'b0, 1'b1, 16'h1234, 1'b0);
        check("unblank_write", 64'({fb_wr_en, fb_wr_addr, fb_wr_data}), 64'({1'b1, 16'd1, 16'h1234}));
        cycle(1'b0, 1'b0, 16'h0, 1'b1);
`endif

        // Asynchronous reset while a write is pending.
        cycle(1'b0, 1'b1, 16'h0ABC, 1'b0);
        check("pending_before_reset", 64'(fb_wr_en), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", 64'(dut_vec()), 64'(52'h8000000000000));
        frame_start = 1'b0;
        pix_valid   = 1'b0;
        fb_wr_ack   = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();

        // Randomised traffic with occasional resynchronisation.
        for (int i = 0; i < 3000; i++) begin
`ifdef PIXEL_FB_FORCED_BLANK_EN
            forced_blank = ($urandom_range(0, 7) == 0);
`endif
            cycle(($urandom_range(0, 399) == 0), ($urandom_range(0, 3) != 0),
                  16'($urandom), ($urandom_range(0, 2) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
